regs_mp: RTL and testbench

REGS_MP -- requirements
Module: regs_mp

---
 rtl/regs_mp.sv | 147 ++++++++++++++
 tb/tb_regs_mp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regs_mp.sv
// Multi-ported register file with combinational core read ports, write-through
// bypass, and a debug access port whose writes yield to core writes up to a timeout.
module regs_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_RD      = 2,
    parameter int DBG_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_ack_o,
    output logic                     dbg_err_o,
    output logic [DATA_W-1:0]        dbg_rdata_o
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [7:0] TMO_LAST = 8'(DBG_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } dbg_state_t;

    logic [DATA_W-1:0] mem_r [NREG];
    dbg_state_t        state_r, state_s;
    logic [7:0]        cnt_r, cnt_s;
    logic              ack_r, err_r;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              dbg_wr_s, dbg_cap_s, dbg_abort_s;
    logic [DATA_W-1:0] dbg_rd_s;

    // Core read ports: register 0 is hardwired zero, a same-cycle core write bypasses
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;
        assign ra_s = raddr_i[k*ADDR_W +: ADDR_W];

        // Per-port read mux
        always_comb begin
            if (ra_s == ZERO_ADDR) begin
                rd_s = {DATA_W{1'b0}};
            end else if (we_i && (ra_s == waddr_i)) begin
                rd_s = wdata_i;
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign rdata_o[k*DATA_W +: DATA_W] = rd_s;
    end

    // Debug read path uses the same bypass as the core ports
    always_comb begin
        if (dbg_addr_i == ZERO_ADDR) begin
            dbg_rd_s = {DATA_W{1'b0}};
        end else if (we_i && (dbg_addr_i == waddr_i)) begin
            dbg_rd_s = wdata_i;
        end else begin
            dbg_rd_s = mem_r[dbg_addr_i];
        end
    end

    // Debug FSM next-state; a core write always wins against a debug write
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dbg_wr_s    = 1'b0;
        dbg_cap_s   = 1'b0;
        dbg_abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!dbg_req_i) begin
                    cnt_s = 8'd0;
                end else if (!dbg_we_i) begin
                    dbg_cap_s = 1'b1;
                    state_s   = ST_ACK;
                end else if (!we_i) begin
                    dbg_wr_s = 1'b1;
                    cnt_s    = 8'd0;
                    state_s  = ST_ACK;
                end else if (cnt_r == TMO_LAST) begin
                    dbg_abort_s = 1'b1;
                    cnt_s       = 8'd0;
                    state_s     = ST_ACK;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // FSM state, block counter and registered debug outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            dbg_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= (state_s == ST_ACK);
            err_r   <= dbg_abort_s;
            if (dbg_cap_s) begin
                dbg_rdata_r <= dbg_rd_s;
            end
        end
    end

    // Register array; register 0 is never written and stays at its reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            if (waddr_i != ZERO_ADDR) begin
                mem_r[waddr_i] <= wdata_i;
            end
        end else if (dbg_wr_s && (dbg_addr_i != ZERO_ADDR)) begin
            mem_r[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    assign dbg_ack_o   = ack_r;
    assign dbg_err_o   = err_r;
    assign dbg_rdata_o = dbg_rdata_r;

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: vector table for the core ports, scoreboard
// queue for debug transactions, hand sequences for timeout and reset corners.
module tb_regs_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [9:0]  raddr_i;
    logic [63:0] rdata_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic        dbg_err_o;
    logic [31:0] dbg_rdata_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    typedef struct {
        logic        is_rd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    vec_t vecs[9];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regs_mp dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .dbg_req_i  (dbg_req_i),
        .dbg_we_i   (dbg_we_i),
        .dbg_addr_i (dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i),
        .dbg_ack_o  (dbg_ack_o),
        .dbg_err_o  (dbg_err_o),
        .dbg_rdata_o(dbg_rdata_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a0, input logic [31:0] e0,
                            input logic [4:0] a1, input logic [31:0] e1);
        raddr_i = {a1, a0};
        #1;
        check({name, "_p0"}, rdata_o[31:0], e0);
        check({name, "_p1"}, rdata_o[63:32], e1);
    endtask

    // Debug transaction: core writes ca/cd during cycles 1..blk of the request
    task automatic dbg_op(input string name, input logic w, input logic [4:0] a,
                          input logic [31:0] wd, input int blk, input logic [4:0] ca,
                          input logic [31:0] cd, input logic e_err,
                          input logic [31:0] e_rd, input int e_lat);
        exp_t e;
        int   cyc;
        bit   got;
        bit   bad_err;
        e.is_rd = !w;
        e.err   = e_err;
        e.rdata = e_rd;
        e.lat   = e_lat;
        exp_q.push_back(e);
        dbg_req_i   = 1'b1;
        dbg_we_i    = w;
        dbg_addr_i  = a;
        dbg_wdata_i = wd;
        waddr_i     = ca;
        wdata_i     = cd;
        cyc = 1;
        got = 1'b0;
        bad_err = 1'b0;
        while (!got && cyc <= 40) begin
            we_i = (cyc <= blk);
            tick();
            cyc++;
            if (dbg_ack_o) got = 1'b1;
            else if (dbg_err_o) bad_err = 1'b1;
        end
        dbg_req_i = 1'b0;
        we_i      = 1'b0;
        e = exp_q.pop_front();
        check({name, "_ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_latency"}, 32'(cyc), 32'(e.lat));
            check({name, "_err"}, 32'(dbg_err_o), 32'(e.err));
            if (e.is_rd) check({name, "_rdata"}, dbg_rdata_o, e.rdata);
        end
        check({name, "_err_outside_ack"}, 32'(bad_err), 32'd0);
        tick();
        check({name, "_ack_one_cycle"}, 32'(dbg_ack_o), 32'd0);
        check({name, "_err_after_ack"}, 32'(dbg_err_o), 32'd0);
    endtask

    initial begin
        int acks;
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd3,  32'h00000000, 32'h00000000};
        vecs[4] = '{1'b1, 5'd3,  32'h11112222, 5'd3,  5'd5,  32'h11112222, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd3,  32'hCAFEF00D, 32'h11112222};
        vecs[6] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd0,  32'hCAFEF00D, 32'h00000000};
        vecs[7] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd31, 32'h00000000, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd3,  32'h00000000, 32'h11112222};

        rst = 1'b0;
        we_i = 1'b0;
        waddr_i = 5'd0;
        wdata_i = 32'd0;
        raddr_i = 10'd0;
        dbg_req_i = 1'b0;
        dbg_we_i = 1'b0;
        dbg_addr_i = 5'd0;
        dbg_wdata_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(dbg_ack_o), 32'd0);
        check("reset_err", 32'(dbg_err_o), 32'd0);
        check("reset_dbg_rdata", dbg_rdata_o, 32'd0);
        rst = 1'b1;
        tick();

        for (int a = 0; a < 32; a++) begin
            rd_check("reset_read", 5'(a), 32'd0, 5'(31 - a), 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            we_i    = vecs[i].we;
            waddr_i = vecs[i].wa;
            wdata_i = vecs[i].wd;
            raddr_i = {vecs[i].r1, vecs[i].r0};
            #1;
            check($sformatf("vec%0d_p0", i), rdata_o[31:0], vecs[i].e0);
            check($sformatf("vec%0d_p1", i), rdata_o[63:32], vecs[i].e1);
            tick();
        end
        we_i = 1'b0;

        dbg_op("dbg_rd_bypass", 1'b0, 5'd5, 32'd0, 1, 5'd5, 32'h12345678, 1'b0, 32'h12345678, 2);
        rd_check("after_bypass", 5'd5, 32'h12345678, 5'd3, 32'h11112222);

        dbg_op("dbg_wr_blk3", 1'b1, 5'd7, 32'hA5A5A5A5, 3, 5'd8, 32'h88888888, 1'b0, 32'd0, 5);
        rd_check("after_blk3", 5'd7, 32'hA5A5A5A5, 5'd8, 32'h88888888);

        dbg_op("dbg_wr9", 1'b1, 5'd9, 32'h0F0F0F0F, 0, 5'd0, 32'd0, 1'b0, 32'd0, 2);
        dbg_op("dbg_timeout", 1'b1, 5'd9, 32'h99999999, 100, 5'd10, 32'h10101010, 1'b1, 32'd0, 16);
        rd_check("after_timeout", 5'd9, 32'h0F0F0F0F, 5'd10, 32'h10101010);

        dbg_op("dbg_blk14", 1'b1, 5'd12, 32'hC0C0C0C0, 14, 5'd13, 32'h13131313, 1'b0, 32'd0, 16);
        rd_check("after_blk14", 5'd12, 32'hC0C0C0C0, 5'd13, 32'h13131313);

        dbg_op("dbg_wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 1'b0, 32'd0, 2);
        rd_check("after_wr0", 5'd0, 32'd0, 5'd7, 32'hA5A5A5A5);
        dbg_op("dbg_rd7", 1'b1 ^ 1'b1, 5'd7, 32'd0, 0, 5'd0, 32'd0, 1'b0, 32'hA5A5A5A5, 2);
        dbg_op("dbg_rd0", 1'b0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 2);

        // Debug write is not bypassed to the read ports
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b1;
        dbg_addr_i = 5'd3;
        dbg_wdata_i = 32'h33333333;
        rd_check("dbg_wr_nobypass", 5'd3, 32'h11112222, 5'd0, 32'd0);
        tick();
        dbg_req_i = 1'b0;
        check("dbg_wr3_ack", 32'(dbg_ack_o), 32'd1);
        rd_check("dbg_wr3_visible", 5'd3, 32'h33333333, 5'd0, 32'd0);
        tick();

        // Reset in the middle of a blocked debug write
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b1;
        dbg_addr_i = 5'd9;
        dbg_wdata_i = 32'h77777777;
        we_i = 1'b1;
        waddr_i = 5'd14;
        wdata_i = 32'hEEEEEEEE;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("midreset_ack", 32'(dbg_ack_o), 32'd0);
        tick();
        tick();
        dbg_req_i = 1'b0;
        we_i = 1'b0;
        rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dbg_ack_o) acks++;
        end
        check("midreset_no_ack", 32'(acks), 32'd0);
        check("midreset_dbg_rdata", dbg_rdata_o, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_check("midreset_read", 5'(a), 32'd0, 5'(31 - a), 32'd0);
        end
        dbg_op("post_reset_blk14", 1'b1, 5'd4, 32'h44444444, 14, 5'd6, 32'h66666666, 1'b0, 32'd0, 16);
        rd_check("post_reset_read", 5'd4, 32'h44444444, 5'd6, 32'h66666666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
